// File: rtl/game_datapath_gen.sv
// Memory-game datapath: setup, seconds timers, LFSR target, entry compare, rounds, BCD score, 7-seg display.
// Strobes act on the next clock_50 edge; flags and display are registered one cycle behind the state.
module game_datapath_gen #(
    parameter int              CLK_HZ     = 50000000,
    parameter int              SW_W       = 8,
    parameter int              LEVEL_W    = 2,
    parameter int              ROUND_W    = 4,
    parameter int              TIME_LIMIT = 9,
    parameter int              SHOW_SEC   = 2,
    parameter logic [SW_W-1:0] SEED       = SW_W'(8'hA5)
) (
    input  logic            clock_50,
    input  logic            reset,
    input  logic [3:0]      key,
    input  logic [SW_W-1:0] switch,
    input  logic            clr_game,
    input  logic            clr_time,
    input  logic            en_setup,
    input  logic            en_time,
    input  logic            en_user,
    input  logic            en_round,
    input  logic            sel,
    output logic [6:0]      hex0,
    output logic [6:0]      hex1,
    output logic [6:0]      hex2,
    output logic [6:0]      hex3,
    output logic [6:0]      hex4,
    output logic [6:0]      hex5,
    output logic [SW_W-1:0] leds,
    output logic            end_fpga,
    output logic            end_user,
    output logic            end_time,
    output logic            win,
    output logic            match
);
    localparam int NUM_LEVELS = 2 ** LEVEL_W;
    localparam int SLICE_W    = SW_W / NUM_LEVELS;
    localparam int PRE_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

    localparam logic [6:0] SEG_L = 7'h0E;
    localparam logic [6:0] SEG_T = 7'h0F;
    localparam logic [6:0] SEG_R = 7'h05;
    localparam logic [6:0] SEG_U = 7'h3E;
    localparam logic [6:0] SEG_S = 7'h5B;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;
    localparam logic [6:0] SEG_P = 7'h67;
    localparam logic [6:0] SEG_G = 7'h5E;
    localparam logic [6:0] SEG_A = 7'h77;

    // Right-shifting Galois feedback masks of maximal-length polynomials
    function automatic logic [31:0] taps_for(input int w);
        case (w)
            2:       return 32'h3;
            3:       return 32'h6;
            4:       return 32'hC;
            5:       return 32'h14;
            6:       return 32'h30;
            7:       return 32'h60;
            9:       return 32'h110;
            10:      return 32'h240;
            11:      return 32'h500;
            12:      return 32'hE08;
            13:      return 32'h1C80;
            14:      return 32'h3802;
            15:      return 32'h6000;
            16:      return 32'hD008;
            default: return 32'hB8;
        endcase
    endfunction

    localparam logic [SW_W-1:0] TAPS = SW_W'(taps_for(SW_W));

    function automatic logic [SW_W-1:0] mask_for(input logic [LEVEL_W-1:0] lvl);
        logic [SW_W-1:0] m;
        int              n;
        n = (int'(lvl) + 1) * SLICE_W;
        m = '0;
        for (int i = 0; i < SW_W; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0:    return 7'h7E;
            4'h1:    return 7'h30;
            4'h2:    return 7'h6D;
            4'h3:    return 7'h79;
            4'h4:    return 7'h33;
            4'h5:    return 7'h5B;
            4'h6:    return 7'h5F;
            4'h7:    return 7'h70;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h7B;
            4'hA:    return 7'h77;
            4'hB:    return 7'h1F;
            4'hC:    return 7'h4E;
            4'hD:    return 7'h3D;
            4'hE:    return 7'h4F;
            default: return 7'h47;
        endcase
    endfunction

    logic [LEVEL_W-1:0] level_q, level_d;
    logic [ROUND_W-1:0] goal_q, goal_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [3:0]         show_q, show_d;
    logic [3:0]         countdown_q, countdown_d;
    logic [SW_W-1:0]    lfsr_q, lfsr_d;
    logic [SW_W-1:0]    user_q, user_d;
    logic               user_vld_q, user_vld_d;
    logic               match_q, match_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         ones_q, ones_d;
    logic               win_q, win_d;
    logic [1:0]         sync_q, sync_d;
    logic               key_prev_q, key_prev_d;
    logic               end_user_q, end_user_d;
    logic [SW_W-1:0]    leds_q, leds_d;
    logic [6:0]         hex_q [6];
    logic [6:0]         hex_d [6];

    logic [SW_W-1:0]    mask_q;
    logic               tick;
    logic [7:0]         score_sum;
    logic               unused_keys;

    assign unused_keys = ^key[3:1];
    assign mask_q      = mask_for(level_q);

    always_comb begin
        level_d     = level_q;
        goal_d      = goal_q;
        presc_d     = presc_q;
        show_d      = show_q;
        countdown_d = countdown_q;
        lfsr_d      = lfsr_q;
        user_d      = user_q;
        user_vld_d  = user_vld_q;
        round_d     = round_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        tick        = 1'b0;
        score_sum   = 8'd0;

        if (en_setup) begin
            level_d = switch[SW_W-1 -: LEVEL_W];
            goal_d  = (switch[ROUND_W-1:0] == '0) ? ROUND_W'(1) : switch[ROUND_W-1:0];
        end

        // clr_game restarts the timers too: a new game always begins with a fresh show phase
        if (clr_time || clr_game) begin
            presc_d     = '0;
            show_d      = 4'(SHOW_SEC);
            countdown_d = 4'(TIME_LIMIT);
        end else if (en_time) begin
            tick    = (presc_q == PRE_MAX);
            presc_d = tick ? '0 : presc_q + PRE_W'(1);
            if (tick && show_q != 4'd0) begin
                show_d = show_q - 4'd1;
            end
            if (tick && show_q == 4'd0 && countdown_q != 4'd0) begin
                countdown_d = countdown_q - 4'd1;
            end
        end

        if (clr_game) begin
            lfsr_d     = SEED;
            user_d     = '0;
            user_vld_d = 1'b0;
            round_d    = '0;
            tens_d     = 4'd0;
            ones_d     = 4'd0;
        end else if (en_round) begin
            if (match_q) begin
                score_sum = 8'(tens_q) * 8'd10 + 8'(ones_q) + 8'(level_q) + 8'd1;
                if (score_sum > 8'd99) begin
                    score_sum = 8'd99;
                end
                tens_d = 4'(score_sum / 8'd10);
                ones_d = 4'(score_sum % 8'd10);
            end
            if (round_q != '1) begin
                round_d = round_q + ROUND_W'(1);
            end
            lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
            user_d     = '0;
            user_vld_d = 1'b0;
        end else if (en_user) begin
            user_d     = switch & mask_q;
            user_vld_d = 1'b1;
        end

        // Compare against the next-state target so a level change re-evaluates a latched entry
        match_d = user_vld_d && (user_d == (lfsr_d & mask_for(level_d)));
        win_d   = !clr_game && (round_q >= goal_q) && (goal_q != '0);
        leds_d  = (show_d != 4'd0) ? (lfsr_d & mask_for(level_d)) : '0;

        sync_d     = {sync_q[0], key[0]};
        key_prev_d = sync_q[1];
        end_user_d = key_prev_q & ~sync_q[1];

        for (int i = 0; i < 6; i++) begin
            hex_d[i] = 7'h00;
        end
        if (!sel) begin
            hex_d[5] = SEG_L;
            hex_d[4] = seg7(4'(level_q));
            hex_d[3] = SEG_T;
            hex_d[2] = seg7(countdown_q);
            hex_d[1] = SEG_R;
            hex_d[0] = seg7(4'(round_q));
        end else begin
            if (win_q) begin
                hex_d[5] = SEG_U;
                hex_d[4] = SEG_S;
                hex_d[3] = SEG_E;
                hex_d[2] = SEG_R;
            end else begin
                hex_d[5] = SEG_F;
                hex_d[4] = SEG_P;
                hex_d[3] = SEG_G;
                hex_d[2] = SEG_A;
            end
            hex_d[1] = seg7(tens_q);
            hex_d[0] = seg7(ones_q);
        end
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            level_q     <= '0;
            goal_q      <= '0;
            presc_q     <= '0;
            show_q      <= 4'(SHOW_SEC);
            countdown_q <= 4'(TIME_LIMIT);
            lfsr_q      <= SEED;
            user_q      <= '0;
            user_vld_q  <= 1'b0;
            match_q     <= 1'b0;
            round_q     <= '0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            win_q       <= 1'b0;
            sync_q      <= 2'b00;
            key_prev_q  <= 1'b0;
            end_user_q  <= 1'b0;
            leds_q      <= '0;
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= 7'h00;
            end
        end else begin
            level_q     <= level_d;
            goal_q      <= goal_d;
            presc_q     <= presc_d;
            show_q      <= show_d;
            countdown_q <= countdown_d;
            lfsr_q      <= lfsr_d;
            user_q      <= user_d;
            user_vld_q  <= user_vld_d;
            match_q     <= match_d;
            round_q     <= round_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            win_q       <= win_d;
            sync_q      <= sync_d;
            key_prev_q  <= key_prev_d;
            end_user_q  <= end_user_d;
            leds_q      <= leds_d;
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    assign hex0     = hex_q[0];
    assign hex1     = hex_q[1];
    assign hex2     = hex_q[2];
    assign hex3     = hex_q[3];
    assign hex4     = hex_q[4];
    assign hex5     = hex_q[5];
    assign leds     = leds_q;
    assign end_fpga = (show_q == 4'd0);
    assign end_time = (countdown_q == 4'd0);
    assign end_user = end_user_q;
    assign win      = win_q;
    assign match    = match_q;

endmodule

// File: tb/tb_game_datapath_gen.sv
// Directed and randomized checks of game_datapath_gen against a behavioural game model.
module tb_game_datapath_gen;
    logic       clock_50 = 1'b0;
    logic       reset, clr_game, clr_time, en_setup, en_time, en_user, en_round, sel;
    logic [3:0] key;
    logic [7:0] switch;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [7:0] leds;
    logic       end_fpga, end_user, end_time, win, match;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the game state
    int         m_level, m_goal, m_round, m_score, m_cd;
    logic [7:0] m_lfsr, m_user;
    bit         m_vld;

    always #5 clock_50 = ~clock_50;

    game_datapath_gen #(.CLK_HZ(4), .SW_W(8), .LEVEL_W(2), .ROUND_W(4),
                        .TIME_LIMIT(3), .SHOW_SEC(2), .SEED(8'hA5)) dut (
        .clock_50(clock_50), .reset(reset), .key(key), .switch(switch),
        .clr_game(clr_game), .clr_time(clr_time), .en_setup(en_setup), .en_time(en_time),
        .en_user(en_user), .en_round(en_round), .sel(sel),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .leds(leds), .end_fpga(end_fpga), .end_user(end_user), .end_time(end_time),
        .win(win), .match(match));

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock_50);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_mask(input int lvl);
        return 8'((1 << ((lvl + 1) * 2)) - 1);
    endfunction

    // Feedback polynomial x^8 + x^6 + x^5 + x^4 + 1 in right-shifting Galois form
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        logic [7:0] poly;
        poly = 8'((1 << 7) | (1 << 5) | (1 << 4) | (1 << 3));
        return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
    endfunction

    function automatic logic [7:0] m_target();
        return m_lfsr & m_mask(m_level);
    endfunction

    function automatic bit exp_match();
        return m_vld && (m_user == m_target());
    endfunction

    function automatic bit exp_win();
        return (m_goal != 0) && (m_round >= m_goal);
    endfunction

    function automatic logic [6:0] seg_of(input byte ch);
        string      s;
        logic [6:0] r;
        int         idx;
        case (ch)
            "0": s = "abcdef";   "1": s = "bc";      "2": s = "abdeg";   "3": s = "abcdg";
            "4": s = "bcfg";     "5": s = "acdfg";   "6": s = "acdefg";  "7": s = "abc";
            "8": s = "abcdefg";  "9": s = "abcdfg";  "A": s = "abcefg";  "b": s = "cdefg";
            "C": s = "adef";     "d": s = "bcdeg";   "E": s = "adefg";   "F": s = "aefg";
            "L": s = "def";      "t": s = "defg";    "r": s = "eg";      "U": s = "bcdef";
            "S": s = "acdfg";    "P": s = "abefg";   "G": s = "acdef";
            default: s = "";
        endcase
        r = '0;
        for (int i = 0; i < s.len(); i++) begin
            idx = 6 - (int'(s[i]) - 97);
            r[idx] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_clear();
        m_lfsr  = 8'hA5;
        m_round = 0;
        m_score = 0;
        m_user  = 8'h00;
        m_vld   = 1'b0;
        m_cd    = 3;
    endtask

    task automatic check_all(input bit sel_v, input string tag);
        string hc;
        byte   e[6];
        hc  = "0123456789AbCdEF";
        sel = sel_v;
        cyc(2);
        chk({tag, ":match"}, match, exp_match());
        chk({tag, ":win"}, win, exp_win());
        chk({tag, ":leds"}, leds, m_target());
        if (!sel_v) begin
            e[5] = "L"; e[4] = hc[m_level]; e[3] = "t"; e[2] = hc[m_cd];
            e[1] = "r"; e[0] = hc[m_round];
        end else begin
            if (exp_win()) begin
                e[5] = "U"; e[4] = "S"; e[3] = "E"; e[2] = "r";
            end else begin
                e[5] = "F"; e[4] = "P"; e[3] = "G"; e[2] = "A";
            end
            e[1] = hc[m_score / 10];
            e[0] = hc[m_score % 10];
        end
        chk({tag, ":hex5"}, hex5, seg_of(e[5]));
        chk({tag, ":hex4"}, hex4, seg_of(e[4]));
        chk({tag, ":hex3"}, hex3, seg_of(e[3]));
        chk({tag, ":hex2"}, hex2, seg_of(e[2]));
        chk({tag, ":hex1"}, hex1, seg_of(e[1]));
        chk({tag, ":hex0"}, hex0, seg_of(e[0]));
    endtask

    task automatic do_setup(input logic [7:0] sw, input bit with_clr);
        switch   = sw;
        en_setup = 1'b1;
        clr_game = with_clr;
        cyc(1);
        en_setup = 1'b0;
        clr_game = 1'b0;
        m_level  = int'(sw[7:6]);
        m_goal   = (sw[3:0] == 4'd0) ? 1 : int'(sw[3:0]);
        if (with_clr) model_clear();
    endtask

    task automatic do_user(input logic [7:0] sw);
        switch  = sw;
        en_user = 1'b1;
        cyc(1);
        en_user = 1'b0;
        m_user  = sw & m_mask(m_level);
        m_vld   = 1'b1;
    endtask

    task automatic model_round();
        if (exp_match()) m_score = (m_score + m_level + 1 > 99) ? 99 : m_score + m_level + 1;
        if (m_round < 15) m_round++;
        m_lfsr = lfsr_next(m_lfsr);
        m_user = 8'h00;
        m_vld  = 1'b0;
    endtask

    task automatic do_round(input bit with_user);
        en_round = 1'b1;
        en_user  = with_user;
        cyc(1);
        en_round = 1'b0;
        en_user  = 1'b0;
        model_round();
    endtask

    task automatic do_clr(input bit with_round);
        clr_game = 1'b1;
        en_round = with_round;
        cyc(1);
        clr_game = 1'b0;
        en_round = 1'b0;
        model_clear();
    endtask

    task automatic match_round();
        do_user((8'($urandom) & ~m_mask(m_level)) | m_target());
        do_round(1'b0);
    endtask

    initial begin
        int         cnt, at, distinct, mism;
        logic [7:0] start;
        bit         seen [256];

        reset = 1'b1; clr_game = 0; clr_time = 0; en_setup = 0; en_time = 0;
        en_user = 0; en_round = 0; sel = 0; key = 4'hF; switch = 8'h00;
        m_level = 0; m_goal = 0;
        model_clear();
        cyc(2);
        chk("rst:leds", leds, 8'h00);
        chk("rst:end_fpga", end_fpga, 1'b0);
        chk("rst:end_time", end_time, 1'b0);
        chk("rst:end_user", end_user, 1'b0);
        chk("rst:win", win, 1'b0);
        chk("rst:match", match, 1'b0);
        reset = 1'b0;
        check_all(1'b0, "rst_disp");

        // Setup level 1, goal 3: target is the low nibble of the seed
        do_setup(8'b01_00_0011, 1'b0);
        chk("setup:leds", leds, 8'h05);
        check_all(1'b0, "setup");

        // Timers: 4-cycle seconds, 2 s show, 3 s countdown
        en_time = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            chk($sformatf("timer%0d:end_fpga", k), end_fpga, k >= 8);
            chk($sformatf("timer%0d:end_time", k), end_time, k >= 20);
            chk($sformatf("timer%0d:leds", k), leds, (k < 8) ? 8'h05 : 8'h00);
        end
        clr_time = 1'b1;
        cyc(1);
        clr_time = 1'b0;
        en_time  = 1'b0;
        chk("reload:end_time", end_time, 1'b0);
        chk("reload:end_fpga", end_fpga, 1'b0);
        chk("reload:leds", leds, 8'h05);

        // Matching then mismatching entry
        do_user(8'hA0 | m_target());
        chk("entry:match", match, 1'b1);
        do_round(1'b0);
        check_all(1'b1, "round1");
        check_all(1'b0, "round1_game");
        do_user(m_target() ^ 8'h01);
        chk("miss:match", match, 1'b0);
        do_round(1'b0);
        check_all(1'b1, "miss");

        // Three matched rounds reach goal 3
        do_clr(1'b0);
        check_all(1'b1, "cleared");
        for (int r = 0; r < 3; r++) begin
            match_round();
            check_all(1'b1, $sformatf("win_r%0d", r));
        end

        // Level 3 with goal 0 (stored as 1), setup together with clear; score saturates at 99
        do_setup(8'b11_00_0000, 1'b1);
        check_all(1'b0, "lvl3");
        for (int r = 0; r < 26; r++) match_round();
        check_all(1'b1, "sat_res");
        check_all(1'b0, "sat_game");

        // Full LFSR period observed on the LEDs at level 3
        start    = leds;
        distinct = 0;
        mism     = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 255; i++) begin
            do_round(1'b0);
            if (!seen[leds]) distinct++;
            seen[leds] = 1'b1;
            if (leds !== m_lfsr) mism++;
        end
        chk("lfsr:distinct", distinct, 255);
        chk("lfsr:zero", seen[0], 1'b0);
        chk("lfsr:wrap", leds, start);
        chk("lfsr:model", mism, 0);

        // Randomized strobe sequences
        do_clr(1'b0);
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 6))
                0, 1: do_user((8'($urandom) & ~m_mask(m_level)) | m_target());
                2:    do_user(8'($urandom));
                3:    do_round(1'b0);
                4:    do_round(1'b1);
                5:    do_setup(8'($urandom), $urandom_range(0, 3) == 0);
                default: do_clr($urandom_range(0, 1) == 1);
            endcase
            check_all($urandom_range(0, 1) == 1, $sformatf("rnd%0d", it));
        end

        // Key: one pulse, three cycles after the falling edge
        sel = 1'b0;
        key = 4'hE;
        cnt = 0;
        at  = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc(1);
            if (end_user) begin
                cnt++;
                at = c;
            end
        end
        chk("key:pulses", cnt, 1);
        chk("key:latency", at, 3);
        key = 4'hF;
        cyc(5);
        chk("key:release", end_user, 1'b0);

        // Reset during a held key cancels the pulse and restores reset state
        key = 4'hE;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(1);
            if (end_user) cnt++;
        end
        chk("key_rst:pulses", cnt, 0);
        key = 4'hF;
        m_level = 0;
        m_goal  = 0;
        model_clear();
        check_all(1'b0, "post_rst");
        check_all(1'b1, "post_rst_res");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/game_datapath_gen.md
Name: game_datapath_gen

Overview:
Parametrised successor to the memory-game datapath. It holds game setup, a seconds prescaler and countdown, an LFSR target-sequence generator with level masking, user-entry latch and compare, a round counter, a BCD score accumulator, and registered six-digit display generation. The block is driven by the game control FSM through clear/enable strobes and returns status flags to it. Generalised in switch width, round count, time limit and level count; adds sequence generation, scoring, key edge detection and registered display.

Parameters:
CLK_HZ, 50000000, clock cycles per one-second tick
SW_W, 8, switch and LED width; must be divisible by NUM_LEVELS
LEVEL_W, 2, width of level field; NUM_LEVELS = 2**LEVEL_W
ROUND_W, 4, round counter width; rounds 1..2**ROUND_W-1
TIME_LIMIT, 9, countdown start in seconds, 1..9
SHOW_SEC, 2, seconds the target is shown on LEDs, 1..9
SEED, 8'hA5, LFSR seed, nonzero, SW_W bits

Ports:
clock_50  in  1  system clock
reset  in  1  synchronous, active-high; clears all state
key  in  4  push buttons, active-low, asynchronous
switch  in  SW_W  setup and user entry
clr_game  in  1  clear round, score and LFSR (same as reset except setup register)
clr_time  in  1  reload countdown and show timers, clear prescaler
en_setup  in  1  latch setup from switch
en_time  in  1  enable prescaler and countdown
en_user  in  1  latch user entry
en_round  in  1  score current round and advance round/LFSR
sel  in  1  0 = game screen, 1 = result screen
hex0..hex5  out  7 each  segments {a,b,c,d,e,f,g}, MSB = a, active-high
leds  out  SW_W  target pattern during show phase
end_fpga  out  1  show phase elapsed
end_user  out  1  one-cycle pulse on key[0] press
end_time  out  1  countdown at zero
win  out  1  target round count reached
match  out  1  latched entry equals masked target

Behaviour:
- All registers update on the rising edge of clock_50. On reset: setup, round, score and prescaler = 0; LFSR = SEED; countdown = TIME_LIMIT; show = SHOW_SEC. Reset values of all outputs: 0, except hex0..hex5, which equal the decoded reset state one cycle after reset.
- Setup: on en_setup, level = switch[SW_W-1 -: LEVEL_W] and goal = switch[ROUND_W-1:0]. A goal of 0 is stored as 1.
- Mask: the low (level+1)*SW_W/NUM_LEVELS bits are set. target = lfsr & mask.
- Prescaler:
  - Counts 0..CLK_HZ-1 while en_time=1 and holds while en_time=0.
  - tick = 1 for one cycle on wrap.
  - clr_time has priority over en_time.
- Show timer: decrements on tick while nonzero. end_fpga = (show==0). leds = target while show!=0, else 0.
- Countdown: decrements on tick only when show==0 and countdown!=0, then holds at 0. end_time = (countdown==0). clr_time reloads both timers the same cycle.
- Entry: on en_user, user = switch & mask. match = (user == target), registered; valid 1 cycle after en_user.
- Round, on en_round:
  - If match, score += level+1 as BCD, saturating at 99.
  - round += 1, saturating at 2**ROUND_W-1.
  - LFSR advances one step (Galois, maximal-length taps for SW_W, never reaches 0).
  - user and match clear.
- win is registered as (round >= goal) && goal != 0.
- Simultaneous strobes: clr_game beats en_round, and en_round beats en_user. en_setup together with clr_game latches setup and clears the game.
- Key: key[0] passes through a 2-flop synchroniser. end_user pulses one cycle on the 1->0 transition. A held key produces no repeat pulse.
- Display, registered, 1-cycle latency:
  - sel=0: hex5 'L', hex4 digit(level), hex3 't', hex2 digit(countdown), hex1 'r', hex0 digit(round, hex 0-F).
  - sel=1, win=1: "USEr" on hex5..hex2.
  - sel=1, win=0: "FPGA" on hex5..hex2.
  - sel=1, either case: hex1/hex0 show the score tens/units.
- Reset mid-game restores all reset values within one cycle, including a pending end_user pulse.

Test Plan:
1. Reset, then en_setup with switch=8'b01_00_0011 -> level=1, goal=3, mask=8'h0F, leds=SEED&0F (4'h5) during show phase.
2. CLK_HZ=4, SHOW_SEC=2, TIME_LIMIT=3, en_time held -> end_fpga at cycle 8, end_time at cycle 20 and held; clr_time at cycle 21 reloads both timers, so end_time=0 and end_fpga=0 next cycle.
3. en_user with switch equal to target -> match=1 next cycle; en_round -> score 02, round 1, match=0. Mismatched entry -> score unchanged.
4. Three matching rounds at level 1 with goal 3 -> win=1. sel=1 -> hex5..hex2 = "USEr", hex1/hex0 = '0'/'6'.
5. Score saturation: level 3, 26 matched rounds -> score 99, no BCD overflow.
6. Hold key[0] low for 10 cycles -> exactly one end_user pulse, 3 cycles after the falling edge. Reset asserted during the hold -> no pulse.
